execute_stage: RTL and testbench

Execute stage of the five-stage MIPS pipeline, directly upstream of the memory stage. Registers the decoded instruction, computes the ALU result that becomes the memory stage's address/bypass value, and forwards control bundle, store data, destination register and sequential PC. Contains an iterative 32-cycle multiply/divide unit with HI/LO registers and raises a pipeline stall while an instruction in execute needs that unit and it is busy.

---
 rtl/execute_stage.sv | 221 ++++++++++++++++++++++
 tb/tb_execute_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage: input register set, ALU, and an iterative 32-cycle
// multiply/divide unit with HI/LO. Stalls upstream while an MD instruction
// sits in execute and the unit is still busy.
//
// state | meaning
// IDLE  | MD unit free; MD ops in execute start, MTHI/MTLO write, MFHI/MFLO read
// BUSY  | one multiply/divide iteration per cycle, count 0..31
module execute_stage #(
    parameter logic [7:0]  BUNDLE_RST = 8'h31,
    parameter int unsigned MD_CYCLES  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  bundle_in,
    input  logic [3:0]  alu_op_in,
    input  logic [3:0]  md_op_in,
    input  logic        alu_src_in,
    input  logic [31:0] reg_a_in,
    input  logic [31:0] reg_b_in,
    input  logic [31:0] imm_in,
    input  logic [4:0]  shamt_in,
    input  logic [4:0]  write_reg_in,
    input  logic [31:0] pc_seq_in,
    output logic [7:0]  bundle_out,
    output logic [31:0] address_out,
    output logic [31:0] reg_b_out,
    output logic [4:0]  write_reg_out,
    output logic [31:0] pc_seq_out,
    output logic        stall_out
);
    localparam logic [4:0] CNT_LAST = 5'(MD_CYCLES - 1);

    localparam logic [3:0] MD_MULT = 4'd1, MD_MULTU = 4'd2, MD_DIV = 4'd3, MD_DIVU = 4'd4;
    localparam logic [3:0] MD_MFHI = 4'd5, MD_MFLO = 4'd6, MD_MTHI = 4'd7, MD_MTLO = 4'd8;

    typedef enum logic {ST_IDLE, ST_BUSY} md_state_e;

    md_state_e   state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;

    logic [7:0]  bundle_q;
    logic [3:0]  alu_op_q, md_op_q;
    logic        alu_src_q;
    logic [31:0] reg_a_q, reg_b_q, imm_q, pc_seq_q;
    logic [4:0]  shamt_q, write_reg_q;

    logic        is_div_q, neg_lo_q, neg_hi_q;
    logic [31:0] mag_q, w_hi_q, w_lo_q, hi_q, lo_q;

    logic        md_arith, md_any, md_load, md_step, md_done;

    assign md_arith  = (md_op_q >= MD_MULT) && (md_op_q <= MD_DIVU);
    assign md_any    = (md_op_q >= MD_MULT) && (md_op_q <= MD_MTLO);
    assign stall_out = (state_q == ST_BUSY) && md_any;

    // Input register set; held while the stage is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            bundle_q    <= BUNDLE_RST;
            alu_op_q    <= '0;
            md_op_q     <= '0;
            alu_src_q   <= 1'b0;
            reg_a_q     <= '0;
            reg_b_q     <= '0;
            imm_q       <= '0;
            shamt_q     <= '0;
            write_reg_q <= '0;
            pc_seq_q    <= '0;
        end else if (!stall_out) begin
            bundle_q    <= bundle_in;
            alu_op_q    <= alu_op_in;
            md_op_q     <= md_op_in;
            alu_src_q   <= alu_src_in;
            reg_a_q     <= reg_a_in;
            reg_b_q     <= reg_b_in;
            imm_q       <= imm_in;
            shamt_q     <= shamt_in;
            write_reg_q <= write_reg_in;
            pc_seq_q    <= pc_seq_in;
        end
    end

    // MD state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // MD next state and datapath strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        md_load = 1'b0;
        md_step = 1'b0;
        md_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (md_arith) begin
                    state_d = ST_BUSY;
                    cnt_d   = '0;
                    md_load = 1'b1;
                end
            end
            ST_BUSY: begin
                md_step = 1'b1;
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == CNT_LAST) begin
                    md_done = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture: iterate on magnitudes, remember which results to negate.
    // A zero divisor keeps the raw dividend so the remainder comes out unchanged.
    logic        op_signed, op_div, b_zero, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, a_div;

    assign op_signed = (md_op_q == MD_MULT) || (md_op_q == MD_DIV);
    assign op_div    = (md_op_q == MD_DIV) || (md_op_q == MD_DIVU);
    assign b_zero    = (reg_b_q == 32'd0);
    assign a_neg     = op_signed && reg_a_q[31];
    assign b_neg     = op_signed && reg_b_q[31];
    assign a_mag     = a_neg ? -reg_a_q : reg_a_q;
    assign b_mag     = b_neg ? -reg_b_q : reg_b_q;
    assign a_div     = b_zero ? reg_a_q : a_mag;

    // One iteration: shift-add multiply or restoring divide step.
    logic [32:0] mul_sum, div_shift, div_sub;
    logic        div_ge;
    logic [31:0] it_hi, it_lo, fin_hi, fin_lo;
    logic [63:0] prod;

    assign mul_sum   = {1'b0, w_hi_q} + (w_lo_q[0] ? {1'b0, mag_q} : 33'd0);
    assign div_shift = {w_hi_q, w_lo_q[31]};
    assign div_ge    = div_shift >= {1'b0, mag_q};
    assign div_sub   = div_shift - {1'b0, mag_q};
    assign it_hi     = is_div_q ? (div_ge ? div_sub[31:0] : div_shift[31:0]) : mul_sum[32:1];
    assign it_lo     = is_div_q ? {w_lo_q[30:0], div_ge} : {mul_sum[0], w_lo_q[31:1]};
    assign prod      = neg_lo_q ? -{it_hi, it_lo} : {it_hi, it_lo};
    assign fin_hi    = is_div_q ? (neg_hi_q ? -it_hi : it_hi) : prod[63:32];
    assign fin_lo    = is_div_q ? (neg_lo_q ? -it_lo : it_lo) : prod[31:0];

    // MD working registers and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            mag_q    <= '0;
            w_hi_q   <= '0;
            w_lo_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            if (md_load) begin
                is_div_q <= op_div;
                neg_lo_q <= (a_neg ^ b_neg) && !(op_div && b_zero);
                neg_hi_q <= op_div && a_neg && !b_zero;
                mag_q    <= op_div ? b_mag : a_mag;
                w_hi_q   <= '0;
                w_lo_q   <= op_div ? a_div : b_mag;
            end else if (md_step) begin
                w_hi_q <= it_hi;
                w_lo_q <= it_lo;
            end
            if (md_done) begin
                hi_q <= fin_hi;
            end else if (state_q == ST_IDLE && md_op_q == MD_MTHI) begin
                hi_q <= reg_a_q;
            end
            if (md_done) begin
                lo_q <= fin_lo;
            end else if (state_q == ST_IDLE && md_op_q == MD_MTLO) begin
                lo_q <= reg_a_q;
            end
        end
    end

    // ALU on the registered operands.
    logic [31:0] op_b, alu_res;
    assign op_b = alu_src_q ? imm_q : reg_b_q;

    always_comb begin
        alu_res = op_b;
        case (alu_op_q)
            4'd0:  alu_res = reg_a_q + op_b;
            4'd1:  alu_res = reg_a_q - op_b;
            4'd2:  alu_res = reg_a_q & op_b;
            4'd3:  alu_res = reg_a_q | op_b;
            4'd4:  alu_res = reg_a_q ^ op_b;
            4'd5:  alu_res = ~(reg_a_q | op_b);
            4'd6:  alu_res = {31'd0, $signed(reg_a_q) < $signed(op_b)};
            4'd7:  alu_res = {31'd0, reg_a_q < op_b};
            4'd8:  alu_res = op_b << shamt_q;
            4'd9:  alu_res = op_b >> shamt_q;
            4'd10: alu_res = $signed(op_b) >>> shamt_q;
            4'd11: alu_res = op_b << reg_a_q[4:0];
            4'd12: alu_res = op_b >> reg_a_q[4:0];
            4'd13: alu_res = $signed(op_b) >>> reg_a_q[4:0];
            4'd14: alu_res = {op_b[15:0], 16'h0000};
            default: alu_res = op_b;
        endcase
    end

    assign address_out   = (md_op_q == MD_MFHI) ? hi_q :
                           (md_op_q == MD_MFLO) ? lo_q : alu_res;
    assign bundle_out    = stall_out ? BUNDLE_RST : bundle_q;
    assign write_reg_out = stall_out ? 5'd0 : write_reg_q;
    assign reg_b_out     = reg_b_q;
    assign pc_seq_out    = pc_seq_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed scenarios plus random instruction stream,
// all checked each cycle against a transaction-level reference model.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  bundle_in;
    logic [3:0]  alu_op_in, md_op_in;
    logic        alu_src_in;
    logic [31:0] reg_a_in, reg_b_in, imm_in, pc_seq_in;
    logic [4:0]  shamt_in, write_reg_in;
    logic [7:0]  bundle_out;
    logic [31:0] address_out, reg_b_out, pc_seq_out;
    logic [4:0]  write_reg_out;
    logic        stall_out;

    execute_stage #(.BUNDLE_RST(8'h31), .MD_CYCLES(32)) dut (
        .clk(clk), .reset(reset),
        .bundle_in(bundle_in), .alu_op_in(alu_op_in), .md_op_in(md_op_in),
        .alu_src_in(alu_src_in), .reg_a_in(reg_a_in), .reg_b_in(reg_b_in),
        .imm_in(imm_in), .shamt_in(shamt_in), .write_reg_in(write_reg_in),
        .pc_seq_in(pc_seq_in), .bundle_out(bundle_out), .address_out(address_out),
        .reg_b_out(reg_b_out), .write_reg_out(write_reg_out),
        .pc_seq_out(pc_seq_out), .stall_out(stall_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  bundle;
        logic [3:0]  alu;
        logic [3:0]  md;
        logic        src;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [4:0]  wr;
        logic [31:0] pc;
    } instr_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: instruction in execute, HI/LO, busy cycles left.
    instr_t      cur;
    bit          busy;
    int          busy_left;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input instr_t x);
        logic [31:0] bb;
        bb = x.src ? x.imm : x.b;
        case (x.alu)
            4'd0:  return x.a + bb;
            4'd1:  return x.a - bb;
            4'd2:  return x.a & bb;
            4'd3:  return x.a | bb;
            4'd4:  return x.a ^ bb;
            4'd5:  return ~(x.a | bb);
            4'd6:  return ($signed(x.a) < $signed(bb)) ? 32'd1 : 32'd0;
            4'd7:  return (x.a < bb) ? 32'd1 : 32'd0;
            4'd8:  return bb << x.shamt;
            4'd9:  return bb >> x.shamt;
            4'd10: return 32'($signed(bb) >>> x.shamt);
            4'd11: return bb << x.a[4:0];
            4'd12: return bb >> x.a[4:0];
            4'd13: return 32'($signed(bb) >>> x.a[4:0]);
            4'd14: return {bb[15:0], 16'h0000};
            default: return bb;
        endcase
    endfunction

    task automatic md_result(input instr_t x, output logic [31:0] h, output logic [31:0] l);
        logic [63:0] p;
        longint q, r;
        h = '0; l = '0;
        case (x.md)
            4'd1: begin
                p = 64'(longint'($signed(x.a)) * longint'($signed(x.b)));
                h = p[63:32]; l = p[31:0];
            end
            4'd2: begin
                p = {32'd0, x.a} * {32'd0, x.b};
                h = p[63:32]; l = p[31:0];
            end
            4'd3: begin
                if (x.b == 0) begin h = x.a; l = 32'hFFFF_FFFF; end
                else begin
                    q = longint'($signed(x.a)) / longint'($signed(x.b));
                    r = longint'($signed(x.a)) % longint'($signed(x.b));
                    l = 32'(q); h = 32'(r);
                end
            end
            4'd4: begin
                if (x.b == 0) begin h = x.a; l = 32'hFFFF_FFFF; end
                else begin l = x.a / x.b; h = x.a % x.b; end
            end
            default: ;
        endcase
    endtask

    function automatic bit m_stall();
        return busy && (cur.md >= 4'd1) && (cur.md <= 4'd8);
    endfunction

    task automatic model_reset();
        cur = '0;
        cur.bundle = 8'h31;
        busy = 0; busy_left = 0;
        m_hi = '0; m_lo = '0;
    endtask

    task automatic model_edge(input instr_t x);
        bit stall_b;
        stall_b = m_stall();
        if (busy) begin
            busy_left--;
            if (busy_left == 0) begin busy = 0; m_hi = p_hi; m_lo = p_lo; end
        end else if (cur.md >= 4'd1 && cur.md <= 4'd4) begin
            busy = 1; busy_left = 32;
            md_result(cur, p_hi, p_lo);
        end else if (cur.md == 4'd7) m_hi = cur.a;
        else if (cur.md == 4'd8) m_lo = cur.a;
        if (!stall_b) cur = x;
    endtask

    task automatic check_outputs();
        bit s;
        s = m_stall();
        chk("stall_out", {31'd0, stall_out}, {31'd0, s});
        chk("bundle_out", {24'd0, bundle_out}, s ? 32'h31 : {24'd0, cur.bundle});
        chk("write_reg_out", {27'd0, write_reg_out}, s ? 32'd0 : {27'd0, cur.wr});
        chk("address_out", address_out,
            (cur.md == 4'd5) ? m_hi : (cur.md == 4'd6) ? m_lo : ref_alu(cur));
        chk("reg_b_out", reg_b_out, cur.b);
        chk("pc_seq_out", pc_seq_out, cur.pc);
    endtask

    task automatic drive(input instr_t x);
        bundle_in = x.bundle; alu_op_in = x.alu; md_op_in = x.md; alu_src_in = x.src;
        reg_a_in = x.a; reg_b_in = x.b; imm_in = x.imm; shamt_in = x.shamt;
        write_reg_in = x.wr; pc_seq_in = x.pc;
    endtask

    task automatic step(input instr_t x);
        drive(x);
        @(posedge clk); #1;
        model_edge(x);
        check_outputs();
    endtask

    // Present x until it sits in execute with no stall; returns stalled cycles.
    task automatic send(input instr_t x, output int stalls);
        int guard;
        stalls = 0;
        guard = 0;
        step(x);
        while (stall_out === 1'b1 && guard < 40) begin
            stalls++;
            chk("bubble_bundle", {24'd0, bundle_out}, 32'h31);
            step(x);
            guard++;
        end
        chk("stall_release", {31'd0, stall_out}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive('0);
        @(posedge clk); #1;
        model_reset();
        check_outputs();
        reset = 1'b0;
    endtask

    function automatic instr_t mk(input logic [3:0] alu, input logic [3:0] md, input logic src,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] imm, input logic [4:0] shamt);
        instr_t x;
        x.bundle = 8'($urandom); x.alu = alu; x.md = md; x.src = src;
        x.a = a; x.b = b; x.imm = imm; x.shamt = shamt;
        x.wr = 5'($urandom); x.pc = $urandom;
        return x;
    endfunction

    function automatic logic [31:0] rval();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic instr_t rand_instr();
        logic [3:0] md;
        md = ($urandom_range(0, 15) < 10) ? 4'd0 : 4'($urandom_range(1, 15));
        return mk(4'($urandom_range(0, 15)), md, 1'($urandom), rval(), rval(), rval(),
                  5'($urandom));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        instr_t nop;
        reset = 1'b0;
        drive('0);
        nop = mk(4'd0, 4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);

        // Reset values
        do_reset();
        chk("rst_bundle", {24'd0, bundle_out}, 32'h31);
        chk("rst_address", address_out, 32'd0);
        chk("rst_stall", {31'd0, stall_out}, 32'd0);

        // ALU corners
        send(mk(4'd0, 4'd0, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'd0, 5'd0), s);
        chk("add_wrap", address_out, 32'h8000_0000);
        send(mk(4'd6, 4'd0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0), s);
        chk("slt", address_out, 32'd1);
        send(mk(4'd7, 4'd0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0), s);
        chk("sltu", address_out, 32'd0);
        send(mk(4'd10, 4'd0, 1'b0, 32'd0, 32'h8000_0000, 32'd0, 5'd4), s);
        chk("sra", address_out, 32'hF800_0000);
        send(mk(4'd14, 4'd0, 1'b1, 32'd0, 32'd0, 32'h0000_1234, 5'd0), s);
        chk("lui", address_out, 32'h1234_0000);

        // MULT then back-to-back MFLO/MFHI
        send(mk(4'd0, 4'd1, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd0), s);
        chk("mult_no_stall", s, 32'd0);
        send(mk(4'd0, 4'd6, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0), s);
        chk("mflo_stall_cycles", s, 32'd32);
        chk("mult_lo", address_out, 32'hFFFF_FFFE);
        send(mk(4'd0, 4'd5, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0), s);
        chk("mult_hi", address_out, 32'hFFFF_FFFF);

        // Signed divide and divide by zero
        send(mk(4'd0, 4'd3, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd0, 5'd0), s);
        send(mk(4'd0, 4'd6, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0), s);
        chk("div_lo", address_out, 32'hFFFF_FFFD);
        send(mk(4'd0, 4'd5, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0), s);
        chk("div_hi", address_out, 32'hFFFF_FFFF);
        send(mk(4'd0, 4'd4, 1'b0, 32'd100, 32'd0, 32'd0, 5'd0), s);
        send(mk(4'd0, 4'd6, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0), s);
        chk("divu0_lo", address_out, 32'hFFFF_FFFF);
        send(mk(4'd0, 4'd5, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0), s);
        chk("divu0_hi", address_out, 32'd100);
        send(mk(4'd0, 4'd3, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 5'd0), s);
        send(mk(4'd0, 4'd6, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0), s);
        chk("div_ovf_lo", address_out, 32'h8000_0000);

        // Independent ops flow while the unit is busy
        send(mk(4'd0, 4'd2, 1'b0, $urandom, $urandom, 32'd0, 5'd0), s);
        send(mk(4'd0, 4'd0, 1'b0, 32'd5, 32'd7, 32'd0, 5'd0), s);
        chk("busy_add_stall", s, 32'd0);
        chk("busy_add", address_out, 32'd12);
        send(mk(4'd0, 4'd0, 1'b1, 32'h1000, 32'hCAFE_F00D, 32'h0000_0040, 5'd0), s);
        chk("busy_lw_stall", s, 32'd0);
        chk("busy_lw_addr", address_out, 32'h1040);
        chk("busy_sw_data", reg_b_out, 32'hCAFE_F00D);

        // MD op arriving in the completion cycle stalls exactly once
        send(mk(4'd0, 4'd1, 1'b0, $urandom, $urandom, 32'd0, 5'd0), s);  // waits out prior op
        for (int i = 0; i < 31; i++) send(nop, s);
        send(mk(4'd0, 4'd2, 1'b0, $urandom, $urandom, 32'd0, 5'd0), s);
        chk("completion_overlap_stall", s, 32'd1);

        // MTLO then MFLO
        send(mk(4'd0, 4'd8, 1'b0, 32'hDEAD_BEEF, 32'd0, 32'd0, 5'd0), s);
        send(mk(4'd0, 4'd6, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0), s);
        chk("mtlo_mflo_stall", s, 32'd0);
        chk("mtlo_mflo", address_out, 32'hDEAD_BEEF);

        // Reset mid-divide at count 10
        send(mk(4'd0, 4'd4, 1'b0, 32'd12345, 32'd7, 32'd0, 5'd0), s);
        for (int i = 0; i < 11; i++) step(nop);
        do_reset();
        chk("midrst_stall", {31'd0, stall_out}, 32'd0);
        chk("midrst_bundle", {24'd0, bundle_out}, 32'h31);
        send(mk(4'd0, 4'd5, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0), s);
        chk("midrst_mfhi", address_out, 32'd0);

        // Random stream
        for (int i = 0; i < 300; i++) send(rand_instr(), s);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
